aes_uart_cmd_ctrl: RTL and testbench



---
 rtl/aes_uart_cmd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_aes_uart_cmd_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_uart_cmd_ctrl.sv
// UART-side command responder for the AES-128 core: parses SET_KEY/ENC/DEC, collects a 16-byte payload,
// drives the core strobes and returns a status byte plus 16 result bytes for ENC/DEC.
module aes_uart_cmd_ctrl #(
   parameter logic [7:0]  CMD_SET_KEY  = 8'h00,
   parameter logic [7:0]  CMD_ENC      = 8'h02,
   parameter logic [7:0]  CMD_DEC      = 8'h03,
   parameter logic [7:0]  ST_ERR_CMD   = 8'hFF,
   parameter logic [7:0]  ST_ERR_NOKEY = 8'hFE,
   parameter logic [23:0] TIMEOUT      = 24'd5_000_000
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         i_fRxDone,
   input  logic [7:0]   i_RxData,
   output logic         o_fTx,
   output logic [7:0]   o_TxData,
   input  logic         i_fTxDone,
   input  logic         i_fTxReady,
   output logic         o_fKeyLoad,
   output logic         o_fStart,
   output logic         o_fDec,
   output logic [127:0] o_Key,
   output logic [127:0] o_Text,
   input  logic         i_fCoreDone,
   input  logic [127:0] i_Result
);

   typedef enum logic [2:0] {
      IDLE, RX_PAY, ACK_REQ, ACK_WAIT, CORE_WAIT, RES_REQ, RES_WAIT
   } state_t;

   state_t         r_state;
   logic [7:0]     r_cmd;
   logic [7:0]     r_status;
   logic [127:0]   r_shreg;
   logic [3:0]     r_cnt;
   logic [23:0]    r_tmo;
   logic           r_key_vld;
   logic           r_pay_full;
   logic           r_started;
   logic           r_core_pend;
   logic           w_cmd_ok;

   assign w_cmd_ok = (i_RxData == CMD_SET_KEY) || (i_RxData == CMD_ENC) || (i_RxData == CMD_DEC);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state     <= IDLE;
         r_cmd       <= 8'h00;
         r_status    <= 8'h00;
         r_shreg     <= '0;
         r_cnt       <= 4'd0;
         r_tmo       <= 24'd0;
         r_key_vld   <= 1'b0;
         r_pay_full  <= 1'b0;
         r_started   <= 1'b0;
         r_core_pend <= 1'b0;
         o_fTx       <= 1'b0;
         o_TxData    <= 8'h00;
         o_fKeyLoad  <= 1'b0;
         o_fStart    <= 1'b0;
         o_fDec      <= 1'b0;
         o_Key       <= '0;
         o_Text      <= '0;
      end else begin
         o_fTx      <= 1'b0;
         o_fKeyLoad <= 1'b0;
         o_fStart   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_started   <= 1'b0;
               r_core_pend <= 1'b0;
               r_pay_full  <= 1'b0;
               if (i_fRxDone) begin
                  if (w_cmd_ok) begin
                     r_cmd   <= i_RxData;
                     r_cnt   <= 4'd0;
                     r_tmo   <= 24'd0;
                     r_state <= RX_PAY;
                  end else begin
                     r_status <= ST_ERR_CMD;
                     r_state  <= ACK_REQ;
                  end
               end
            end
            RX_PAY: begin
               // The cycle after the 16th byte executes the command; any byte in that cycle is dropped.
               if (r_pay_full) begin
                  r_pay_full <= 1'b0;
                  r_state    <= ACK_REQ;
                  if (r_cmd == CMD_SET_KEY) begin
                     o_Key      <= r_shreg;
                     o_fKeyLoad <= 1'b1;
                     r_key_vld  <= 1'b1;
                     r_status   <= CMD_SET_KEY;
                  end else if (r_key_vld) begin
                     o_Text    <= r_shreg;
                     o_fDec    <= (r_cmd == CMD_DEC);
                     o_fStart  <= 1'b1;
                     r_started <= 1'b1;
                     r_status  <= r_cmd;
                  end else begin
                     r_status <= ST_ERR_NOKEY;
                  end
               end else if (i_fRxDone) begin
                  r_shreg <= {r_shreg[119:0], i_RxData};
                  r_cnt   <= r_cnt + 4'd1;
                  r_tmo   <= 24'd0;
                  if (r_cnt == 4'd15) r_pay_full <= 1'b1;
               end else if (r_tmo == TIMEOUT - 24'd1) begin
                  r_state <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 24'd1;
               end
            end
            ACK_REQ: begin
               if (i_fCoreDone && r_started) begin
                  r_shreg     <= i_Result;
                  r_core_pend <= 1'b1;
               end
               if (i_fTxReady) begin
                  o_fTx    <= 1'b1;
                  o_TxData <= r_status;
                  r_state  <= ACK_WAIT;
               end
            end
            ACK_WAIT: begin
               if (i_fCoreDone && r_started) begin
                  r_shreg     <= i_Result;
                  r_core_pend <= 1'b1;
               end
               if (i_fTxDone) r_state <= r_started ? CORE_WAIT : IDLE;
            end
            CORE_WAIT: begin
               // An early result was already parked in r_shreg while the status byte went out.
               if (r_core_pend) begin
                  r_core_pend <= 1'b0;
                  r_cnt       <= 4'd0;
                  r_state     <= RES_REQ;
               end else if (i_fCoreDone) begin
                  r_shreg <= i_Result;
                  r_cnt   <= 4'd0;
                  r_state <= RES_REQ;
               end
            end
            RES_REQ: begin
               if (i_fTxReady) begin
                  o_fTx    <= 1'b1;
                  o_TxData <= r_shreg[127:120];
                  r_state  <= RES_WAIT;
               end
            end
            RES_WAIT: begin
               if (i_fTxDone) begin
                  r_shreg <= {r_shreg[119:0], 8'h00};
                  r_cnt   <= r_cnt + 4'd1;
                  r_state <= (r_cnt == 4'd15) ? IDLE : RES_REQ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_uart_cmd_ctrl.sv
// Scoreboard bench for aes_uart_cmd_ctrl: randomized command traffic, UART_TX and core models,
// expected bytes/strobes queued at stimulus time and popped by a monitor on DUT output events.
module tb_aes_uart_cmd_ctrl;

   localparam logic [23:0]  TMO = 24'd64;
   localparam logic [127:0] KEY = 128'h5468617473206D79204B756E67204675;
   localparam logic [127:0] PT  = 128'h54776F204F6E65204E696E652054776F;
   localparam logic [127:0] CT  = 128'h29C3505F571420F6402299B31A02D73A;

   logic         Clk = 1'b0;
   logic         Rst = 1'b0;
   logic         i_fRxDone = 1'b0;
   logic [7:0]   i_RxData = 8'h00;
   logic         o_fTx;
   logic [7:0]   o_TxData;
   logic         i_fTxDone = 1'b0;
   logic         i_fTxReady = 1'b1;
   logic         o_fKeyLoad;
   logic         o_fStart;
   logic         o_fDec;
   logic [127:0] o_Key;
   logic [127:0] o_Text;
   logic         i_fCoreDone = 1'b0;
   logic [127:0] i_Result = '0;

   aes_uart_cmd_ctrl #(.TIMEOUT(TMO)) dut (
      .Clk(Clk), .Rst(Rst),
      .i_fRxDone(i_fRxDone), .i_RxData(i_RxData),
      .o_fTx(o_fTx), .o_TxData(o_TxData), .i_fTxDone(i_fTxDone), .i_fTxReady(i_fTxReady),
      .o_fKeyLoad(o_fKeyLoad), .o_fStart(o_fStart), .o_fDec(o_fDec),
      .o_Key(o_Key), .o_Text(o_Text),
      .i_fCoreDone(i_fCoreDone), .i_Result(i_Result)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0]   exp_tx[$];
   logic [127:0] exp_key[$];
   logic [128:0] exp_start[$];

   logic [127:0] m_key = '0;
   bit           m_kv  = 1'b0;

   int           tx_total = 0;
   bit           tx_busy  = 1'b0;
   int           tx_cnt   = 0;
   bit           core_busy = 1'b0;
   int           core_cnt  = 0;
   logic [127:0] core_res  = '0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Stand-in for the AES core: the known test vectors, otherwise an arbitrary reversible-looking mix.
   function automatic logic [127:0] res_fn(input bit dec, input logic [127:0] k, input logic [127:0] t);
      if (!dec && k == KEY && t == PT) return CT;
      if (dec && k == KEY && t == CT) return PT;
      if (dec) return {t[63:0], t[127:64]} ^ k;
      return t ^ {k[7:0], k[127:8]};
   endfunction

   // Monitor plus UART_TX and core models, all in one process so their ordering is fixed.
   always @(negedge Clk) begin
      i_fTxDone   = 1'b0;
      i_fCoreDone = 1'b0;
      if (o_fTx) begin
         chk("tx_overlap", tx_busy, 1'b0);
         if (exp_tx.size() == 0) chk("tx_unexpected", {120'd0, o_TxData}, 128'hx);
         else chk("tx_byte", o_TxData, exp_tx.pop_front());
         tx_total++;
         tx_busy    = 1'b1;
         tx_cnt     = $urandom_range(2, 5);
         i_fTxReady = 1'b0;
      end else if (tx_busy) begin
         if (tx_cnt == 0) begin
            i_fTxDone  = 1'b1;
            tx_busy    = 1'b0;
            i_fTxReady = 1'b1;
         end else tx_cnt--;
      end
      if (o_fKeyLoad) begin
         if (exp_key.size() == 0) chk("keyload_unexpected", 1, 0);
         else chk("keyload_key", o_Key, exp_key.pop_front());
      end
      if (o_fStart) begin
         if (exp_start.size() == 0) chk("start_unexpected", 1, 0);
         else begin
            logic [128:0] e;
            e = exp_start.pop_front();
            chk("start_dec", o_fDec, e[128]);
            chk("start_text", o_Text, e[127:0]);
         end
         core_busy = 1'b1;
         core_cnt  = $urandom_range(0, 25);
         core_res  = res_fn(o_fDec, o_Key, o_Text);
      end else if (core_busy) begin
         if (core_cnt == 0) begin
            i_fCoreDone = 1'b1;
            i_Result    = core_res;
            core_busy   = 1'b0;
         end else core_cnt--;
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge Clk);
      i_fRxDone = 1'b1;
      i_RxData  = b;
      @(negedge Clk);
      i_fRxDone = 1'b0;
      repeat (gap) @(negedge Clk);
   endtask

   // Queue the reference response, then send the command, payload and one byte that must be dropped.
   task automatic run_cmd(input logic [7:0] cmd, input logic [127:0] pl);
      logic [127:0] res;
      if (cmd == 8'h00 || cmd == 8'h02 || cmd == 8'h03) begin
         if (cmd == 8'h00) begin
            exp_key.push_back(pl);
            m_key = pl;
            m_kv  = 1'b1;
            exp_tx.push_back(8'h00);
         end else if (m_kv) begin
            exp_start.push_back({cmd == 8'h03, pl});
            exp_tx.push_back(cmd);
            res = res_fn(cmd == 8'h03, m_key, pl);
            for (int i = 0; i < 16; i++) exp_tx.push_back(res[127 - 8*i -: 8]);
         end else begin
            exp_tx.push_back(8'hFE);
         end
         send_byte(cmd, $urandom_range(0, 3));
         for (int i = 0; i < 16; i++) send_byte(pl[127 - 8*i -: 8], (i == 15) ? 0 : $urandom_range(0, 3));
      end else begin
         exp_tx.push_back(8'hFF);
         send_byte(cmd, 0);
      end
      send_byte(8'($urandom), 0);
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge Clk);
         if (exp_tx.size() == 0 && !tx_busy && !core_busy && exp_start.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, ok, 1'b1);
      repeat (3) @(negedge Clk);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_fTx"}, o_fTx, 0);
      chk({tag, "_TxData"}, o_TxData, 0);
      chk({tag, "_fKeyLoad"}, o_fKeyLoad, 0);
      chk({tag, "_fStart"}, o_fStart, 0);
      chk({tag, "_fDec"}, o_fDec, 0);
      chk({tag, "_Key"}, o_Key, 0);
      chk({tag, "_Text"}, o_Text, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [7:0] c;
      repeat (3) @(negedge Clk);
      chk_outputs_zero("reset");
      Rst = 1'b1;
      repeat (2) @(negedge Clk);

      run_cmd(8'h02, {$urandom, $urandom, $urandom, $urandom});
      wait_idle("nokey_enc");
      run_cmd(8'h05, '0);
      wait_idle("bad_cmd");

      run_cmd(8'h00, KEY);
      wait_idle("set_key");
      run_cmd(8'h02, PT);
      wait_idle("enc_vector");
      run_cmd(8'h03, CT);
      wait_idle("dec_vector");

      // Partial SET_KEY left to time out must leave no trace.
      base = tx_total;
      send_byte(8'h00, 1);
      for (int i = 0; i < 7; i++) send_byte(8'($urandom), $urandom_range(0, 3));
      repeat (int'(TMO) + 5) @(negedge Clk);
      chk("timeout_no_tx", tx_total, base);
      chk("timeout_key_kept", o_Key, m_key);
      run_cmd(8'h00, KEY);
      wait_idle("set_key_after_timeout");

      for (int t = 0; t < 25; t++) begin
         case ($urandom_range(0, 7))
            0:       c = 8'h00;
            1, 2, 3: c = 8'h02;
            4, 5, 6: c = 8'h03;
            default: c = 8'h10 + 8'($urandom_range(0, 200));
         endcase
         run_cmd(c, {$urandom, $urandom, $urandom, $urandom});
         wait_idle("rand_txn");
      end

      // Reset while result byte 8 is in flight.
      run_cmd(8'h00, KEY);
      wait_idle("set_key_pre_reset");
      base = tx_total;
      run_cmd(8'h02, PT);
      for (int c2 = 0; c2 < 2000 && tx_total < base + 9; c2++) @(negedge Clk);
      chk("reached_byte8", tx_total >= base + 9, 1'b1);
      @(posedge Clk);
      #2;
      Rst = 1'b0;
      #1;
      chk_outputs_zero("midrst");
      exp_tx.delete();
      exp_key.delete();
      exp_start.delete();
      m_kv = 1'b0;
      for (int c2 = 0; c2 < 100 && tx_busy; c2++) @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      run_cmd(8'h02, PT);
      wait_idle("enc_after_reset");

      chk("final_tx_queue", exp_tx.size(), 0);
      chk("final_key_queue", exp_key.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
